// File: rtl/flag_update_ctrl.sv
// flag_update_ctrl: two-stage Z/V/N flag pipeline in front of the Flag register,
// with a forwarded youngest-flag view and busy indication for decode.
module flag_update_ctrl #(
   parameter int WIDTH = 16,
   parameter int OP_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alu_valid,
   input  logic [OP_W-1:0]  alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_ovfl,
   input  logic             stall,
   input  logic             flush,
   input  logic [2:0]       cur_flag,
   output logic             flag_we,
   output logic [2:0]       flag_new,
   output logic [2:0]       fwd_flag,
   output logic             flag_busy
);
   logic       s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [2:0] s1_mask_q, s1_mask_d, s1_raw_q, s1_raw_d, s2_flags_q, s2_flags_d;
   logic [2:0] mask, raw, base, merged;
   logic       accept, s1_move;
   always_comb begin
      mask = (alu_op == OP_W'(0) || alu_op == OP_W'(1)) ? 3'b111 :
             (alu_op == OP_W'(2) || alu_op == OP_W'(4) ||
              alu_op == OP_W'(5) || alu_op == OP_W'(6)) ? 3'b100 : 3'b000;
      raw = {alu_result == '0, alu_ovfl, alu_result[WIDTH-1]};
      accept = alu_valid & ~stall & ~flush & (mask != 3'b000);
      // s2 is the immediately older instruction, even if it retires on this edge
      base = s2_valid_q ? s2_flags_q : cur_flag;
      merged = (s1_mask_q & s1_raw_q) | (~s1_mask_q & base);
      s1_move = ~stall & s1_valid_q & ~flush;
      s1_valid_d = flush ? 1'b0 : stall ? s1_valid_q : accept;
      s1_mask_d = stall ? s1_mask_q : accept ? mask : 3'b000;
      s1_raw_d = stall ? s1_raw_q : accept ? raw : 3'b000;
      s2_valid_d = stall ? s2_valid_q : s1_move;
      s2_flags_d = stall ? s2_flags_q : s1_move ? merged : 3'b000;
      flag_we = s2_valid_q & ~stall;
      flag_new = s2_valid_q ? s2_flags_q : 3'b000;
      fwd_flag = s1_valid_q ? merged : s2_valid_q ? s2_flags_q : cur_flag;
      flag_busy = s1_valid_q | s2_valid_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_mask_q  <= 3'b000;
         s1_raw_q   <= 3'b000;
         s2_valid_q <= 1'b0;
         s2_flags_q <= 3'b000;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_mask_q  <= s1_mask_d;
         s1_raw_q   <= s1_raw_d;
         s2_valid_q <= s2_valid_d;
         s2_flags_q <= s2_flags_d;
      end
   end
endmodule

// File: tb/tb_flag_update_ctrl.sv
// tb_flag_update_ctrl: directed vectors checked every cycle against an in-order
// instruction-queue model of the flag pipeline, plus hand-computed expectations.
module tb_flag_update_ctrl;
   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd2, RED = 4'd3, PADDSB = 4'd7;
   logic        clk = 1'b0, rst, alu_valid, alu_ovfl, stall, flush;
   logic [3:0]  alu_op;
   logic [15:0] alu_result;
   logic [2:0]  arch = 3'b000, pre_val, flag_new, fwd_flag;
   logic        pre_en, flag_we, flag_busy;
   int          checks = 0, fails = 0;
   typedef struct {logic [2:0] m; logic [2:0] r; int age;} ent_t;
   ent_t q[$];
   always #5 clk = ~clk;
   flag_update_ctrl #(.WIDTH(16), .OP_W(4)) dut (
      .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_op(alu_op),
      .alu_result(alu_result), .alu_ovfl(alu_ovfl), .stall(stall), .flush(flush),
      .cur_flag(arch), .flag_we(flag_we), .flag_new(flag_new),
      .fwd_flag(fwd_flag), .flag_busy(flag_busy));
   function automatic logic [2:0] op_mask(input logic [3:0] op);
      case (op)
         ADD, SUB: return 3'b111;
         XOR, 4'd4, 4'd5, 4'd6: return 3'b100;
         default: return 3'b000;
      endcase
   endfunction
   // architectural view: cur_flag with the oldest n in-flight instructions applied in order
   function automatic logic [2:0] fold(input logic [2:0] b, input int n);
      logic [2:0] f = b;
      for (int i = 0; i < n; i++) f = (q[i].m & q[i].r) | (~q[i].m & f);
      return f;
   endfunction
   // the Flag register the block drives
   always @(posedge clk) arch <= pre_en ? pre_val : flag_we ? flag_new : arch;
   always @(posedge clk) begin
      if (rst) q.delete();
      else begin
         if (flush && q.size() > 0 && q[q.size()-1].age == 0) q.pop_back();
         if (!stall) begin
            if (q.size() > 0 && q[0].age == 1) q.pop_front();
            foreach (q[i]) q[i].age++;
            if (alu_valid && !flush && op_mask(alu_op) != 3'b000)
               q.push_back('{op_mask(alu_op), {alu_result == 16'h0, alu_ovfl, alu_result[15]}, 0});
         end
      end
   end
   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask
   task automatic compare();
      logic s2;
      s2 = q.size() > 0 && q[0].age == 1;
      chk("model flag_we", {2'b0, flag_we}, {2'b0, s2 & ~stall});
      chk("model flag_new", flag_new, s2 ? fold(arch, 1) : 3'b000);
      chk("model fwd_flag", fwd_flag, fold(arch, q.size()));
      chk("model flag_busy", {2'b0, flag_busy}, {2'b0, q.size() != 0});
   endtask
   task automatic cyc(input logic v, input logic [3:0] op, input logic [15:0] res,
                      input logic ov, input logic st, input logic fl, input logic r);
      @(negedge clk);
      pre_en = 1'b0;
      alu_valid = v; alu_op = op; alu_result = res; alu_ovfl = ov;
      stall = st; flush = fl; rst = r;
      #1 compare();
   endtask
   task automatic idle();
      cyc(1'b0, ADD, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic preload(input logic [2:0] v);
      @(negedge clk);
      {alu_valid, stall, flush, rst} = 4'b0;
      pre_en = 1'b1; pre_val = v;
   endtask
   initial begin
      rst = 1'b1; pre_en = 1'b0; pre_val = 3'b000;
      {alu_valid, alu_ovfl, stall, flush} = 4'b0; alu_op = ADD; alu_result = 16'h0;
      cyc(1'b0, ADD, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, ADD, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset busy", {2'b0, flag_busy}, 3'b000);
      chk("reset we", {2'b0, flag_we}, 3'b000);
      // ADD zero result
      cyc(1'b1, ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      chk("t1 fwd", fwd_flag, 3'b100);
      chk("t1 busy", {2'b0, flag_busy}, 3'b001);
      idle();
      chk("t1 we", {2'b0, flag_we}, 3'b001);
      chk("t1 new", flag_new, 3'b100);
      idle();
      chk("t1 cur", arch, 3'b100);
      chk("t1 busy off", {2'b0, flag_busy}, 3'b000);
      // XOR only updates Z
      preload(3'b111);
      cyc(1'b1, XOR, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      idle();
      chk("t2 new", flag_new, 3'b011);
      // back-to-back SUB, XOR
      preload(3'b000);
      cyc(1'b1, SUB, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, XOR, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3 fwd1", fwd_flag, 3'b011);
      idle();
      chk("t3 we1", {2'b0, flag_we}, 3'b001);
      chk("t3 new1", flag_new, 3'b011);
      chk("t3 fwd2", fwd_flag, 3'b111);
      idle();
      chk("t3 we2", {2'b0, flag_we}, 3'b001);
      chk("t3 new2", flag_new, 3'b111);
      // zero-mask ops never occupy a stage
      cyc(1'b1, PADDSB, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, RED, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t4 busy", {2'b0, flag_busy}, 3'b000);
      chk("t4 fwd", fwd_flag, 3'b111);
      idle();
      chk("t4 we", {2'b0, flag_we}, 3'b000);
      // stall with op in s2
      cyc(1'b1, ADD, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, ADD, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
         chk("t5 stall we", {2'b0, flag_we}, 3'b000);
         chk("t5 stall fwd", fwd_flag, 3'b000);
      end
      idle();
      chk("t5 we", {2'b0, flag_we}, 3'b001);
      chk("t5 new", flag_new, 3'b000);
      idle();
      chk("t5 single", {2'b0, flag_we}, 3'b000);
      // flush squashes ADD in s1
      cyc(1'b1, SUB, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, ADD, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t6 we", {2'b0, flag_we}, 3'b001);
      chk("t6 new", flag_new, 3'b011);
      idle();
      chk("t6 no 2nd we", {2'b0, flag_we}, 3'b000);
      chk("t6 cur", arch, 3'b011);
      // flush with stall still clears s1; stalled op is not accepted
      cyc(1'b1, ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, SUB, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
      idle();
      chk("t6 flush+stall busy", {2'b0, flag_busy}, 3'b000);
      // reset with both stages full
      preload(3'b101);
      cyc(1'b1, ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, XOR, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, ADD, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("t6 full busy", {2'b0, flag_busy}, 3'b001);
      idle();
      chk("t6 rst we", {2'b0, flag_we}, 3'b000);
      chk("t6 rst busy", {2'b0, flag_busy}, 3'b000);
      chk("t6 rst fwd", fwd_flag, 3'b101);
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
